// File: rtl/rot_emu_pkg.sv
// Shared types and constants for the rotary encoder emulator: command opcodes, FSM states,
// the quadrature phase tables and the PB bounce toggle count.
package rot_emu_pkg;

  typedef enum logic [1:0] {
    OP_CW    = 2'd0,
    OP_CCW   = 2'd1,
    OP_SHORT = 2'd2,
    OP_LONG  = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROTATE,
    ST_PRESS,
    ST_GAP
  } state_t;

  localparam int unsigned BOUNCE_TOGGLES = 4;

  // AB pairs, A in bit 1; both directions end a detent on 00
  localparam logic [1:0] CW_PHASES  [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  localparam logic [1:0] CCW_PHASES [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  function automatic logic [1:0] phase_ab(cmd_op_t op, logic [1:0] idx);
    return (op == OP_CCW) ? CCW_PHASES[idx] : CW_PHASES[idx];
  endfunction

endpackage

// File: rtl/rotary_encoder_emu_if.sv
// Command handshake between a requester (master) and the rotary encoder emulator (slave).
interface rotary_encoder_emu_if;
  import rot_emu_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  cmd_op_t    cmd_op;
  logic [3:0] cmd_count;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_count,
    output cmd_ready
  );

endinterface

// File: rtl/rot_emu_timer.sv
// 16-bit loadable down-counter shared by every emulator state; parks at zero.
module rot_emu_timer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic [15:0] value_o,
  output logic        expired_o
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (value_q != 16'd0) begin
      value_d = value_q - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o   = value_q;
  assign expired_o = (value_q == 16'd0);

endmodule

// File: rtl/rotary_encoder_emu.sv
// Rotary encoder emulator: turns one handshaked command into quadrature detents or a timed PB press.
// Define ROT_EMU_BOUNCE_EN to add contact bounce on every PB edge of a press.
module rotary_encoder_emu
  import rot_emu_pkg::*;
#(
  parameter int unsigned STEP_CYCLES        = 16,
  parameter int unsigned SHORT_PRESS_CYCLES = 64,
  parameter int unsigned LONG_PRESS_CYCLES  = 1024,
  parameter int unsigned GAP_CYCLES         = 32
) (
  input  logic                clk,
  input  logic                rstn,
  rotary_encoder_emu_if.slave cmd,
  output logic                A,
  output logic                B,
  output logic                PB,
  output logic                busy,
  output logic                done
);

  if (STEP_CYCLES < 1 || STEP_CYCLES > 65535) begin : g_bad_step
    $error("rotary_encoder_emu: STEP_CYCLES must be within 1..65535");
  end
  if (SHORT_PRESS_CYCLES < 1 || SHORT_PRESS_CYCLES > 65535) begin : g_bad_short
    $error("rotary_encoder_emu: SHORT_PRESS_CYCLES must be within 1..65535");
  end
  if (LONG_PRESS_CYCLES < 1 || LONG_PRESS_CYCLES > 65535) begin : g_bad_long
    $error("rotary_encoder_emu: LONG_PRESS_CYCLES must be within 1..65535");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 65535) begin : g_bad_gap
    $error("rotary_encoder_emu: GAP_CYCLES must be within 1..65535");
  end

  localparam logic [15:0] STEP_LD   = 16'(STEP_CYCLES - 1);
  localparam logic [15:0] SHORT_LEN = 16'(SHORT_PRESS_CYCLES);
  localparam logic [15:0] LONG_LEN  = 16'(LONG_PRESS_CYCLES);
  localparam logic [15:0] GAP_LEN   = 16'(GAP_CYCLES);

  function automatic logic [15:0] press_len(cmd_op_t op);
    return (op == OP_LONG) ? LONG_LEN : SHORT_LEN;
  endfunction

  state_t      state_q, state_d;
  cmd_op_t     op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  phase_q, phase_d;
  logic [1:0]  ab_q, ab_d;
  logic        pb_q, pb_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;

  logic        tmr_load;
  logic [15:0] tmr_val;
  logic [15:0] tmr_value;
  logic        tmr_expired;
  logic        accept;
  logic        bounce_press;
  logic        bounce_gap;

  rot_emu_timer u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .value_o    (tmr_value),
    .expired_o  (tmr_expired)
  );

`ifdef ROT_EMU_BOUNCE_EN
  // Index of the cycle about to be registered, counted from the start of the press or gap.
  logic [15:0] press_next;
  logic [15:0] gap_next;
  localparam logic [15:0] BOUNCE_LEN = 16'(BOUNCE_TOGGLES);

  assign press_next   = press_len(op_q) - tmr_value;
  assign gap_next     = GAP_LEN - tmr_value;
  assign bounce_press = (press_next < BOUNCE_LEN) ? ~press_next[0] : 1'b1;
  assign bounce_gap   = (op_q == OP_SHORT || op_q == OP_LONG) &&
                        (gap_next < BOUNCE_LEN) && gap_next[0];
`else
  logic unused_tmr_value;
  assign unused_tmr_value = ^tmr_value;
  assign bounce_press     = 1'b1;
  assign bounce_gap       = 1'b0;
`endif

  assign accept = cmd.cmd_valid && ready_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    ab_d     = ab_q;
    pb_d     = pb_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = STEP_LD;

    case (state_q)
      ST_IDLE: begin
        ab_d = 2'b00;
        pb_d = 1'b0;
        if (accept) begin
          op_d     = cmd.cmd_op;
          cnt_d    = cmd.cmd_count;
          phase_d  = 2'd0;
          tmr_load = 1'b1;
          if (cmd.cmd_op == OP_CW || cmd.cmd_op == OP_CCW) begin
            state_d = ST_ROTATE;
            tmr_val = STEP_LD;
            ab_d    = (cmd.cmd_count == 4'd0) ? 2'b00 : phase_ab(cmd.cmd_op, 2'd0);
          end else begin
            state_d = ST_PRESS;
            tmr_val = press_len(cmd.cmd_op) - 16'd1;
            pb_d    = 1'b1;
          end
        end
      end

      ST_ROTATE: begin
        // A zero-detent command finishes here without a gap.
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          ab_d    = 2'b00;
        end else if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = STEP_LD;
          if (phase_q == 2'd3) begin
            cnt_d   = cnt_q - 4'd1;
            phase_d = 2'd0;
            if (cnt_q == 4'd1) begin
              state_d = ST_GAP;
              tmr_val = GAP_LEN - 16'd1;
              ab_d    = 2'b00;
            end else begin
              ab_d = phase_ab(op_q, 2'd0);
            end
          end else begin
            phase_d = phase_q + 2'd1;
            ab_d    = phase_ab(op_q, phase_q + 2'd1);
          end
        end
      end

      ST_PRESS: begin
        if (tmr_expired) begin
          state_d  = ST_GAP;
          pb_d     = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = GAP_LEN - 16'd1;
        end else begin
          pb_d = bounce_press;
        end
      end

      ST_GAP: begin
        if (tmr_expired) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          pb_d    = 1'b0;
        end else begin
          pb_d = bounce_gap;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ab_d    = 2'b00;
        pb_d    = 1'b0;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      op_q    <= OP_CW;
      cnt_q   <= '0;
      phase_q <= '0;
      ab_q    <= '0;
      pb_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      ab_q    <= ab_d;
      pb_q    <= pb_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign A             = ab_q[1];
  assign B             = ab_q[0];
  assign PB            = pb_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign cmd.cmd_ready = ready_q;

endmodule

// File: tb/tb_rotary_encoder_emu.sv
// Self-checking bench for rotary_encoder_emu: per-cycle traces against a cycle-list model,
// plus a quadrature decoder and PB high-time count computed from the observed outputs.
module tb_rotary_encoder_emu;
  import rot_emu_pkg::*;

  localparam int STEP  = 4;
  localparam int SHORT = 64;
  localparam int LONG  = 1024;
  localparam int GAP   = 32;
  localparam int BT    = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic A, B, PB, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] exp_q[$];

  rotary_encoder_emu_if cmd_if();

  rotary_encoder_emu #(
    .STEP_CYCLES        (STEP),
    .SHORT_PRESS_CYCLES (SHORT),
    .LONG_PRESS_CYCLES  (LONG),
    .GAP_CYCLES         (GAP)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .cmd  (cmd_if),
    .A    (A),
    .B    (B),
    .PB   (PB),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] model_ab(int op, int p);
    logic [1:0] seq [4];
    if (op == 0) seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    else         seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    return seq[p];
  endfunction

  function automatic int quad_pos(logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Expected {A,B,PB,busy,done,cmd_ready} per cycle, from the accept edge through the done cycle.
  task automatic build_expected(input int op, input int n);
    logic pb;
    exp_q.delete();
    if (op <= 1 && n == 0) begin
      exp_q.push_back(6'b000100);
    end else begin
      if (op <= 1) begin
        for (int d = 0; d < n; d++)
          for (int p = 0; p < 4; p++)
            repeat (STEP) exp_q.push_back({model_ab(op, p), 4'b0100});
      end else begin
        for (int j = 0; j < ((op == 3) ? LONG : SHORT); j++) begin
          pb = 1'b1;
`ifdef ROT_EMU_BOUNCE_EN
          if (j < BT) pb = (j % 2 == 0);
`endif
          exp_q.push_back({2'b00, pb, 3'b100});
        end
      end
      for (int j = 0; j < GAP; j++) begin
        pb = 1'b0;
`ifdef ROT_EMU_BOUNCE_EN
        if (op >= 2 && j < BT) pb = (j % 2 == 1);
`endif
        exp_q.push_back({2'b00, pb, 3'b100});
      end
    end
    exp_q.push_back(6'b000011);
  endtask

  // Caller is at a negedge; returns at the negedge of the done cycle with cmd_valid low.
  task automatic send(input int op, input int n, input bit hold, input string name);
    int         waited = 0;
    int         bad    = 0;
    int         net    = 0;
    int         highs  = 0;
    int         dpos;
    bit         gray_ok = 1'b1;
    logic [5:0] got;
    logic [1:0] prev_ab, cur_ab;
    int         exp_net, exp_highs;

    build_expected(op, n);
    exp_net   = (op == 0) ? 4 * n : (op == 1) ? -4 * n : 0;
    exp_highs = (op == 2) ? SHORT : (op == 3) ? LONG : 0;

    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = cmd_op_t'(2'(op));
    cmd_if.cmd_count = 4'(n);
    while (cmd_if.cmd_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_%s: cmd_ready=%b after %0d cycles, required 1", name, cmd_if.cmd_ready, waited);
      cmd_if.cmd_valid = 1'b0;
      return;
    end

    prev_ab = {A, B};
    for (int j = 0; j < exp_q.size(); j++) begin
      @(negedge clk);
      if (hold && j < exp_q.size() - 1) begin
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = cmd_op_t'(2'($urandom_range(0, 3)));
        cmd_if.cmd_count = 4'($urandom_range(0, 15));
      end else begin
        cmd_if.cmd_valid = 1'b0;
      end
      got = {A, B, PB, busy, done, cmd_if.cmd_ready};
      if (got !== exp_q[j] && bad == 0) begin
        bad = j + 1;
        $display("FAIL trace_%s: cycle %0d {A,B,PB,busy,done,ready}=%b, required %b", name, j, got, exp_q[j]);
      end
      cur_ab = {A, B};
      if (cur_ab != prev_ab) begin
        if ((cur_ab ^ prev_ab) == 2'b11) gray_ok = 1'b0;
        dpos = (quad_pos(cur_ab) - quad_pos(prev_ab) + 4) % 4;
        if (dpos == 1) net++;
        else if (dpos == 3) net--;
      end
      prev_ab = cur_ab;
      if (PB === 1'b1) highs++;
    end

    n_checks++;
    if (bad != 0) n_fail++;
    n_checks++;
    if (gray_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL gray_%s: A and B changed together, required single-bit steps", name);
    end
    n_checks++;
    if (net !== exp_net) begin
      n_fail++;
      $display("FAIL decode_%s: net quadrature steps %0d, required %0d", name, net, exp_net);
    end
    n_checks++;
    if (highs !== exp_highs) begin
      n_fail++;
      $display("FAIL pb_time_%s: PB high for %0d cycles, required %0d", name, highs, exp_highs);
    end
  endtask

  task automatic test_reset();
    int waited = 0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_CW;
    cmd_if.cmd_count = 4'd0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({A, B, PB, busy, done, cmd_if.cmd_ready} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_hold: outputs %b, required 000000", {A, B, PB, busy, done, cmd_if.cmd_ready});
    end
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: cmd_ready=%b one clock after release, required 1", cmd_if.cmd_ready);
    end

    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_CW;
    cmd_if.cmd_count = 4'd2;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    while ({A, B} !== 2'b11 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if ({A, B} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_reach_11: AB=%b after %0d cycles, required 11", {A, B}, waited);
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({A, B, PB, busy, done, cmd_if.cmd_ready} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_async: outputs %b, required 000000", {A, B, PB, busy, done, cmd_if.cmd_ready});
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({A, B, busy, cmd_if.cmd_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_release: {A,B,busy,ready}=%b, required 0001", {A, B, busy, cmd_if.cmd_ready});
    end
  endtask

  task automatic test_rotate_cw();
    send(0, 2, 1'b0, "cw2");
    @(negedge clk);
  endtask

  task automatic test_rotate_ccw();
    send(1, 1, 1'b1, "ccw1");
    @(negedge clk);
  endtask

  task automatic test_zero_count();
    send(0, 0, 1'b0, "cw0");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    send(2, 0, 1'b0, "short");
    send(3, 0, 1'b0, "long");
    send(1, 3, 1'b0, "ccw3_b2b");
    @(negedge clk);
  endtask

  task automatic test_random();
    int op, n;
    bit hold;
    for (int i = 0; i < 8; i++) begin
      op   = $urandom_range(0, 3);
      n    = $urandom_range(0, 15);
      hold = 1'($urandom_range(0, 1));
      send(op, n, hold, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_rotate_cw();
    test_rotate_ccw();
    test_zero_count();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
